// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M types and sign fixup helper for the mul/div unit
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_CALC,
      MD_DONE
   } md_state_e;

   // Two's-complement negation wraps mod 2^(2*XLEN); callers slice out the half they need.
   function automatic logic [2*XLEN-1:0] md_sign_fix(input logic [2*XLEN-1:0] val,
                                                     input logic neg);
      return neg ? -val : val;
   endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// rtl/riscv_muldiv.sv - iterative RV32M multiply/divide unit, one radix-2 step per cycle
module riscv_muldiv #(
   parameter int XLEN       = riscv_pkg::XLEN,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [XLEN-1:0]       op_a,
   input  logic [XLEN-1:0]       op_b,
   input  logic [ADDR_WIDTH-1:0] rd_in,
   output logic                  busy,
   output logic                  done,
   output logic [XLEN-1:0]       result,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr
);
   import riscv_pkg::*;

   localparam int CW = $clog2(XLEN);

   md_state_e             state_q, state_d;
   muldiv_op_e            op_q, op_d;
   logic                  neg_q, neg_d;
   logic [2*XLEN-1:0]     acc_q, acc_d;
   logic [XLEN-1:0]       opb_q, opb_d;
   logic [XLEN-1:0]       result_q, result_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;

   muldiv_op_e        op_in;
   logic              signed_a, signed_b, sign_a, sign_b, is_rem_in, div_zero, div_ovf;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum, rem_sh, rem_sub;
   logic              q_bit;
   logic [2*XLEN-1:0] step, fix_in, fix_out;
   logic [XLEN-1:0]   final_res;

   assign op_in     = muldiv_op_e'(funct3);
   assign signed_a  = op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   assign signed_b  = op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
   assign sign_a    = signed_a && op_a[XLEN-1];
   assign sign_b    = signed_b && op_b[XLEN-1];
   assign mag_a     = sign_a ? -op_a : op_a;
   assign mag_b     = sign_b ? -op_b : op_b;
   assign is_rem_in = op_in inside {MD_REM, MD_REMU};
   assign div_zero  = funct3[2] && (op_b == '0);
   assign div_ovf   = (op_in inside {MD_DIV, MD_REM}) && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (op_b == '1);

   // acc holds {product_hi, multiplier} for MUL* and {remainder, dividend/quotient} for DIV*.
   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
   assign rem_sh  = acc_q[2*XLEN-1:XLEN-1];
   assign rem_sub = rem_sh - {1'b0, opb_q};
   assign q_bit   = rem_sh >= {1'b0, opb_q};
   assign step    = op_q[2] ? {(q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0]),
                               acc_q[XLEN-2:0], q_bit}
                            : {mul_sum, acc_q[XLEN-1:1]};

   always_comb begin
      fix_in = step;
      case (op_q)
         MD_DIV, MD_DIVU: fix_in = {{XLEN{1'b0}}, step[XLEN-1:0]};
         MD_REM, MD_REMU: fix_in = {{XLEN{1'b0}}, step[2*XLEN-1:XLEN]};
         default:         fix_in = step;
      endcase
      fix_out   = md_sign_fix(fix_in, neg_q);
      final_res = (op_q inside {MD_MULH, MD_MULHSU, MD_MULHU}) ? fix_out[2*XLEN-1:XLEN]
                                                              : fix_out[XLEN-1:0];
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      wr_addr_d = wr_addr_q;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               op_d      = op_in;
               wr_addr_d = rd_in;
               cnt_d     = '0;
               if (div_zero) begin
                  result_d = is_rem_in ? op_a : {XLEN{1'b1}};
                  state_d  = MD_DONE;
               end else if (div_ovf) begin
                  result_d = is_rem_in ? {XLEN{1'b0}} : op_a;
                  state_d  = MD_DONE;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, mag_a};
                  opb_d   = mag_b;
                  neg_d   = is_rem_in ? sign_a : (sign_a ^ sign_b);
                  state_d = MD_CALC;
               end
            end
         end
         MD_CALC: begin
            acc_d = step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1)) begin
               result_d = final_res;
               cnt_d    = '0;
               state_d  = MD_DONE;
            end
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= MD_IDLE;
         op_q      <= MD_MUL;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         opb_q     <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         wr_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   assign busy    = (state_q != MD_IDLE);
   assign done    = (state_q == MD_DONE);
   assign wr_en   = done && (wr_addr_q != '0);
   assign result  = result_q;
   assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// tb/tb_riscv_muldiv.sv - randomized self-checking bench for riscv_muldiv against an arithmetic model
module tb_riscv_muldiv;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [4:0]  rd_in = '0;
   logic        busy, done, wr_en;
   logic [31:0] result;
   logic [4:0]  wr_addr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_muldiv #(.XLEN(32), .ADDR_WIDTH(5)) dut (
      .clk     (clk),
      .nrst    (nrst),
      .start   (start),
      .funct3  (funct3),
      .op_a    (op_a),
      .op_b    (op_b),
      .rd_in   (rd_in),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .wr_en   (wr_en),
      .wr_addr (wr_addr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ub, p;
      logic [63:0] pv, up;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      ia = $signed(a);
      ib = $signed(b);
      up = {32'b0, a} * {32'b0, b};
      case (f)
         3'd0: begin p = sa * sb; pv = p; return pv[31:0]; end
         3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
         3'd2: begin p = sa * ub; pv = p; return pv[63:32]; end
         3'd3: return up[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return $urandom_range(0, 255);
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit noise);
      logic [31:0] want;
      int          want_lat, waited;
      bit          fast;
      want = ref_model(f, a, b);
      fast = f[2] && ((b == 0) || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 &&
                                   b == 32'hFFFF_FFFF));
      want_lat = fast ? 0 : 32;
      funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
      @(posedge clk); #1;
      check("busy_on_accept", {31'b0, busy}, 32'd1);
      start  = 1'b0;
      waited = 0;
      while (!done && waited < 100) begin
         if (noise) begin
            start  = 1'($urandom_range(0, 1));
            funct3 = 3'($urandom);
            op_a   = $urandom;
            op_b   = $urandom;
            rd_in  = 5'($urandom);
         end
         @(posedge clk); #1;
         waited++;
      end
      check("done_seen", {31'b0, done}, 32'd1);
      check("latency", waited, want_lat);
      check("result", result, want);
      check("wr_en", {31'b0, wr_en}, {31'b0, rd != 0});
      check("wr_addr", {27'b0, wr_addr}, {27'b0, rd});
      check("busy_in_done", {31'b0, busy}, 32'd1);
      // A start presented during the done cycle must not launch anything.
      start = 1'b1; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_done", {31'b0, done}, 32'd0);
      check("result_held", result, want);
   endtask

   initial begin
      int pulses;
      #12;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_wr_en", {31'b0, wr_en}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
      @(posedge clk); #1;
      nrst = 1'b1;

      run_op(3'd0, 32'd7, 32'd6, 5'd5, 1'b0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1);
      run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 1'b0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
      run_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b0);
      run_op(3'd7, 32'd100, 32'd7, 5'd8, 1'b0);
      run_op(3'd4, 32'd5, 32'd0, 5'd9, 1'b0);
      run_op(3'd6, 32'd5, 32'd0, 5'd10, 1'b0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
      run_op(3'd0, 32'd3, 32'd9, 5'd0, 1'b1);

      funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      nrst = 1'b0;
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_wr_en", {31'b0, wr_en}, 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_wr_addr", {27'b0, wr_addr}, 32'd0);
      @(posedge clk); #1;
      nrst   = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("no_done_after_abort", pulses, 32'd0);
      run_op(3'd4, 32'd1000, 32'd7, 5'd9, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom), pick_operand(), pick_operand(), 5'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
